dmem_access_unit: RTL

//  Data-memory side of the core's load/store path. Takes registered MEM-stage

---
 rtl/dmem_access_unit_if.sv | 22 ++
 rtl/dmem_access_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if
//  Single-outstanding req/ack data-memory bus.
//  req   : request, held high until ack (or abort)
//  we    : 1 = write
//  addr  : word-aligned byte address
//  wdata : store data already placed in its byte lanes
//  be    : byte enables
//  ack   : one-cycle completion from the memory side
//  rdata : read data, valid with ack
//  master = access unit, slave = memory.
interface dmem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//  MEM-stage load/store engine. Decodes a registered load/store request,
//  issues one bus transaction at a time, stalls the pipeline until it
//  completes and returns sign/zero-extended load data.
//  Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_MemRead, i_MemWrite   load / store request
//   i_f3                    funct3 access size/sign
//   i_Addr, i_Wdata         byte address, store data
//   o_Stall                 hold pipeline while access in flight
//   o_Rdata                 extended load data (holds until next load)
//   o_Ex                    one-cycle exception (misaligned/illegal/timeout)
//   bus                     memory bus, master side
module dmem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_MemRead,
    input  logic                 i_MemWrite,
    input  logic [2:0]           i_f3,
    input  logic [31:0]          i_Addr,
    input  logic [31:0]          i_Wdata,
    output logic                 o_Stall,
    output logic [31:0]          o_Rdata,
    output logic                 o_Ex,
    dmem_access_unit_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // Latched request
    logic        we_q;
    logic [29:0] waddr_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    // Request decode
    logic        access, size_ok, misal, bad, go;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        access  = i_MemRead | i_MemWrite;
        size_ok = 1'b0;
        case (i_f3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = ~i_MemWrite;  // unsigned sizes are load-only
            default:                size_ok = 1'b0;
        endcase
        misal = ((i_f3[1:0] == 2'b01) & i_Addr[0]) |
                ((i_f3[1:0] == 2'b10) & (|i_Addr[1:0]));
        bad   = access & ((i_MemRead & i_MemWrite) | ~size_ok | misal);
        go    = access & ~bad;

        case (i_f3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << i_Addr[1:0];
                wdata_d = {4{i_Wdata[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << i_Addr[1:0];
                wdata_d = {2{i_Wdata[15:0]}};
            end
            default: begin
                be_d    = 4'hF;
                wdata_d = i_Wdata;
            end
        endcase
    end

    // Load lane select and extension, from the latched offset/size
    logic [31:0] lane, load_ext;

    always_comb begin
        lane = bus.rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}},  lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // State register and datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (state_q == IDLE && go) begin
                we_q    <= i_MemWrite;
                waddr_q <= i_Addr[31:2];
                off_q   <= i_Addr[1:0];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                f3_q    <= i_f3;
            end
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (go) state_d = REQ;
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.ack) begin
                    // ack beats a same-cycle timeout
                    state_d = DONE;
                    if (!we_q) rdata_d = load_ext;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;  // DONE: inputs ignored, no re-issue
        endcase
    end

    // Outputs; i_rst gates the combinational IDLE terms so nothing leaks
    // from still-asserted request inputs while reset is held.
    always_comb begin
        o_Stall   = 1'b0;
        o_Ex      = 1'b0;
        bus.req   = 1'b0;
        case (state_q)
            IDLE: begin
                o_Stall = go  & ~i_rst;
                o_Ex    = bad & ~i_rst;
            end
            REQ: begin
                o_Stall = 1'b1;
                bus.req = 1'b1;
            end
            default: o_Ex = err_q;  // timeout abort reported in DONE
        endcase
        o_Rdata   = rdata_q;
        bus.we    = we_q;
        bus.addr  = {waddr_q, 2'b00};
        bus.be    = be_q;
        bus.wdata = wdata_q;
    end

endmodule
